// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one non-overlapped request at a time to instruction memory,
// captures the returned word and presents it downstream; redirects squash in-flight words.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [5:0]  if_opcode
);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] req_addr, req_addr_nxt;
   logic [31:0] if_instr_nxt, if_pc_nxt;
   logic        imem_req_nxt, if_valid_nxt;
   logic [31:0] redirect_tgt;

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   assign redirect_tgt = align_pc(redirect_pc);
   assign imem_addr    = req_addr;
   assign if_pc_plus4  = if_pc + 32'd4;
   assign if_opcode    = if_instr[31:26];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         imem_req <= 1'b0;
         if_valid <= 1'b0;
         if_instr <= 32'd0;
         if_pc    <= 32'd0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         req_addr <= req_addr_nxt;
         imem_req <= imem_req_nxt;
         if_valid <= if_valid_nxt;
         if_instr <= if_instr_nxt;
         if_pc    <= if_pc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      req_addr_nxt = req_addr;
      imem_req_nxt = imem_req;
      if_valid_nxt = if_valid;
      if_instr_nxt = if_instr;
      if_pc_nxt    = if_pc;
      unique case (state)
         IDLE: begin
            imem_req_nxt = 1'b1;
            state_nxt    = REQ;
            if (redirect_valid) begin
               pc_nxt       = redirect_tgt;
               req_addr_nxt = redirect_tgt;
            end else begin
               req_addr_nxt = pc;
            end
         end
         REQ: begin
            if (imem_ack) begin
               if (redirect_valid) begin
                  // Returned word belongs to the old path; reissue straight at the target.
                  pc_nxt       = redirect_tgt;
                  req_addr_nxt = redirect_tgt;
               end else begin
                  if_instr_nxt = imem_rdata;
                  if_pc_nxt    = req_addr;
                  if_valid_nxt = 1'b1;
                  pc_nxt       = req_addr + 32'd4;
                  imem_req_nxt = 1'b0;
                  state_nxt    = HOLD;
               end
            end else if (redirect_valid) begin
               pc_nxt    = redirect_tgt;
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            // Old request must still complete before the target can be requested.
            if (redirect_valid) pc_nxt = redirect_tgt;
            if (imem_ack) begin
               req_addr_nxt = redirect_valid ? redirect_tgt : pc;
               state_nxt    = REQ;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               if_valid_nxt = 1'b0;
               pc_nxt       = redirect_tgt;
               req_addr_nxt = redirect_tgt;
               imem_req_nxt = 1'b1;
               state_nxt    = REQ;
            end else if (!stall) begin
               if_valid_nxt = 1'b0;
               req_addr_nxt = pc;
               imem_req_nxt = 1'b1;
               state_nxt    = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected requests and instructions,
// a negedge monitor compares them as the DUT presents new requests / new if_valid words.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [5:0]  if_opcode;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] plus4;
      logic [5:0]  opc;
   } inst_t;

   logic [31:0] exp_req[$];
   inst_t       exp_inst[$];

   int n_cmp = 0;
   int n_err = 0;
   logic mon_en = 1'b0;

   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic [31:0] prev_instr = 32'd0;
   logic [31:0] prev_pc = 32'd0;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_pc_plus4(if_pc_plus4), .if_opcode(if_opcode)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_inst(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] plus4, input logic [5:0] opc);
      inst_t e;
      e.pc = pc; e.instr = instr; e.plus4 = plus4; e.opc = opc;
      exp_inst.push_back(e);
   endtask

   // Monitor: new request = imem_req high after being low or right after an accepted ack.
   always @(negedge clk) begin
      if (mon_en) begin
         if (imem_req && (!prev_req || prev_ack)) begin
            if (exp_req.size() == 0) begin
               check("unexpected_request", imem_addr, 32'hxxxx_xxxx);
            end else begin
               check("req_addr", imem_addr, exp_req.pop_front());
            end
            check("req_while_valid", {31'd0, if_valid}, 32'd0);
         end else if (imem_req && prev_req) begin
            check("req_addr_stable", imem_addr, prev_addr);
         end
         if (if_valid && !prev_valid) begin
            if (exp_inst.size() == 0) begin
               check("unexpected_if_valid", if_pc, 32'hxxxx_xxxx);
            end else begin
               inst_t e;
               e = exp_inst.pop_front();
               check("if_pc", if_pc, e.pc);
               check("if_instr", if_instr, e.instr);
               check("if_pc_plus4", if_pc_plus4, e.plus4);
               check("if_opcode", {26'd0, if_opcode}, {26'd0, e.opc});
               check("req_in_hold", {31'd0, imem_req}, 32'd0);
            end
         end else if (if_valid && prev_valid) begin
            check("hold_instr_stable", if_instr, prev_instr);
            check("hold_pc_stable", if_pc, prev_pc);
            check("req_in_hold", {31'd0, imem_req}, 32'd0);
         end
      end
      prev_req   <= imem_req;
      prev_ack   <= imem_ack;
      prev_valid <= if_valid;
      prev_addr  <= imem_addr;
      prev_instr <= if_instr;
      prev_pc    <= if_pc;
   end

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
      redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
      tick(); tick();
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
      mon_en = 1'b1;

      // First fetch from reset PC, ack after one wait cycle, then sequential request
      exp_req.push_back(32'h0000_0000);
      rst = 1'b0; tick();
      tick();
      imem_ack = 1'b1; imem_rdata = 32'h8C08_0004;
      push_inst(32'h0, 32'h8C08_0004, 32'h4, 6'b100011);
      tick();
      imem_ack = 1'b0;
      exp_req.push_back(32'h0000_0004);
      tick();

      // Stall holds the instruction for 5 cycles, release requests if_pc+4
      tick(); tick();
      imem_ack = 1'b1; imem_rdata = 32'h2001_0005; stall = 1'b1;
      push_inst(32'h4, 32'h2001_0005, 32'h8, 6'b001000);
      tick();
      imem_ack = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("stall_if_valid", {31'd0, if_valid}, 32'd1);
      check("stall_if_pc", if_pc, 32'h4);
      stall = 1'b0;
      exp_req.push_back(32'h0000_0008);
      tick();

      // Redirect during REQ with late ack: word dropped, target aligned
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      check("discard_addr_old", imem_addr, 32'h8);
      tick(); tick();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      exp_req.push_back(32'h0000_0100);
      tick();
      imem_ack = 1'b0;
      check("discard_if_valid", {31'd0, if_valid}, 32'd0);

      // Redirect and ack in the same REQ cycle
      redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
      imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00;
      exp_req.push_back(32'h0000_2000);
      tick();
      redirect_valid = 1'b0; imem_ack = 1'b0;
      check("same_cycle_req", {31'd0, imem_req}, 32'd1);
      check("same_cycle_addr", imem_addr, 32'h2000);
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0008; stall = 1'b1;
      push_inst(32'h2000, 32'h8C22_0008, 32'h2004, 6'b100011);
      tick();
      imem_ack = 1'b0;

      // Redirect in HOLD while stalled, to the top word of the address space
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      exp_req.push_back(32'hFFFF_FFFC);
      tick();
      redirect_valid = 1'b0;
      check("hold_redirect_valid", {31'd0, if_valid}, 32'd0);
      tick();
      imem_ack = 1'b1; imem_rdata = 32'h03E0_0008;
      push_inst(32'hFFFF_FFFC, 32'h03E0_0008, 32'h0, 6'b000000);
      tick();
      imem_ack = 1'b0; stall = 1'b0;
      exp_req.push_back(32'h0000_0000);
      tick();

      // Reset while a request is outstanding; late ack ignored
      rst = 1'b1;
      tick();
      check("rst_mid_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      tick();
      rst = 1'b0;
      exp_req.push_back(32'h0000_0000);
      tick();
      imem_ack = 1'b0;
      tick();
      check("post_rst_req", {31'd0, imem_req}, 32'd1);
      check("post_rst_valid", {31'd0, if_valid}, 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013; stall = 1'b1;
      push_inst(32'h0, 32'h0000_0013, 32'h4, 6'b000000);
      tick();
      imem_ack = 1'b0;

      // Redirect in IDLE straight after reset
      rst = 1'b1;
      tick();
      rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0041;
      exp_req.push_back(32'h0000_0040);
      tick();
      redirect_valid = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hAC01_0000;
      push_inst(32'h40, 32'hAC01_0000, 32'h44, 6'b101011);
      tick();
      imem_ack = 1'b0;
      tick();

      check("req_queue_drained", exp_req.size(), 32'd0);
      check("inst_queue_drained", exp_inst.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
